prog_loader: RTL and testbench

Byte-stream program loader that writes instruction memory and holds the CPU in reset until a complete, checksum-verified program has been written. It receives a framed byte stream over a valid/ready handshake: length, instruction bytes, then checksum. It converts the stream into 16-bit instruction-memory writes, and it releases `cpu_hold` only after the checksum matches. It sits between the host/debug link and `cpu_top`'s instruction memory; the CPU fetch path is the reader of everything this block writes.

---
 rtl/prog_loader_if.sv | 11 +
 rtl/prog_loader.sv | 66 ++++++
 tb/tb_prog_loader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: host byte stream in, instruction-memory write port out
interface prog_loader_if #(parameter int ADDR_W = 8, parameter int INSTR_W = 16);
  logic               s_valid;
  logic [7:0]         s_data;
  logic               s_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  modport master (output s_valid, s_data, input s_ready, imem_we, imem_addr, imem_wdata);
  modport slave (input s_valid, s_data, output s_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: framed byte stream to imem writes; holds the CPU until the checksum verifies
module prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, CSUM, DONE, ERR} state_t;
  state_t            state, nxt;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        n, hi, x;
  logic              acc, last, go;
  assign busy         = state == LEN || state == HI || state == LO || state == CSUM;
  assign bus.s_ready  = busy;
  assign done         = state == DONE;
  assign err          = state == ERR;
  assign cpu_hold     = state != DONE;
  assign acc          = bus.s_valid && bus.s_ready;
  assign last         = idx == ADDR_W'(n - 8'd1);
  assign go           = start && (state == IDLE || state == DONE || state == ERR);
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? LEN : state;
      LEN:             nxt = acc ? (bus.s_data == 8'd0 ? ERR : HI) : LEN;
      HI:              nxt = acc ? LO : HI;
      LO:              nxt = acc ? (last ? CSUM : HI) : LO;
      CSUM:            nxt = acc ? (bus.s_data == x ? DONE : ERR) : CSUM;
      default:         nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx            <= '0;
      n              <= '0;
      hi             <= '0;
      x              <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= acc && state == LO;
      if (acc && state == LO) begin
        bus.imem_addr  <= idx;
        bus.imem_wdata <= INSTR_W'({hi, bus.s_data});
        if (!last) idx <= idx + 1'b1;
      end
      if (acc && state == LEN) n <= bus.s_data;
      if (acc && state == HI) hi <= bus.s_data;
      if (acc && state != CSUM) x <= x ^ bus.s_data;
      if (go) begin
        idx <= '0;
        x   <= '0;
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames with a write scoreboard checked by an independent monitor
module tb_prog_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic cpu_hold, busy, done, err;
  int nvec = 0, nerr = 0;
  logic [23:0] exp_q[$];
  logic [7:0] frm [0:7] = '{8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBC};
  logic prev_we = 1'b0;
  prog_loader_if #(.ADDR_W(8), .INSTR_W(16)) bus ();
  prog_loader #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL write_unexpected: got %h@%h expected none", bus.imem_wdata, bus.imem_addr);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== e) begin
          nerr++;
          $display("FAIL write_data: got %h@%h expected %h@%h", bus.imem_wdata, bus.imem_addr, e[15:0], e[23:16]);
        end
      end
      if (prev_we) begin
        nvec++;
        nerr++;
        $display("FAIL we_width: got 2+ cycle strobe expected 1 cycle");
      end
    end
    prev_we <= bus.imem_we === 1'b1;
  end
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_hold", cpu_hold, 1'b1);
    chk("start_done", done, 1'b0);
    chk("start_err", err, 1'b0);
  endtask
  task automatic load(input logic [7:0] csum, input int gap, input int pulse_at, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      logic lo;
      lo = i >= 2 && i <= 6 && i % 2 == 0;
      chk("s_ready", bus.s_ready, 1'b1);
      bus.s_valid = 1'b1;
      bus.s_data  = i == 7 ? csum : frm[i];
      start       = i == pulse_at;
      if (lo) exp_q.push_back({8'((i - 2) / 2), frm[i-1], frm[i]});
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (lo) chk("we_after_lo", bus.imem_we, 1'b1);
      if (i == 6) chk("done_early", done, 1'b0);
      if (gap > 0) begin
        bus.s_valid = 1'b0;
        repeat (gap) begin
          bus.s_data = 8'($urandom);
          @(negedge clk);
        end
      end
    end
    bus.s_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", bus.s_ready, 1'b0);
    chk("rst_we", bus.imem_we, 1'b0);
    chk("rst_addr", bus.imem_addr == 8'h00, 1'b1);
    chk("rst_wdata", bus.imem_wdata == 16'h0000, 1'b1);
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk) rst = 1'b1;
    bus.s_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", bus.s_ready, 1'b0);
    chk("idle_hold", cpu_hold, 1'b1);
    bus.s_valid = 1'b0;
    // good frame at full rate: done is seen on the 9th edge counting the start edge
    pulse_start();
    load(8'hBC, 0, -1, 8);
    chk("good_done", done, 1'b1);
    chk("good_hold", cpu_hold, 1'b0);
    chk("good_ready", bus.s_ready, 1'b0);
    pulse_start();
    chk("restart_ready", bus.s_ready, 1'b1);
    load(8'hBD, 0, -1, 8);
    chk("bad_err", err, 1'b1);
    chk("bad_hold", cpu_hold, 1'b1);
    chk("bad_done", done, 1'b0);
    chk("bad_ready", bus.s_ready, 1'b0);
    pulse_start();
    load(8'hBC, 2, -1, 8);
    chk("gap_done", done, 1'b1);
    chk("gap_hold", cpu_hold, 1'b0);
    pulse_start();
    load(8'hBC, 0, -1, 4);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", bus.s_ready, 1'b0);
    chk("midrst_hold", cpu_hold, 1'b1);
    chk("midrst_we", bus.imem_we, 1'b0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle", busy, 1'b0);
    pulse_start();
    load(8'hBC, 0, -1, 8);
    chk("after_rst_done", done, 1'b1);
    pulse_start();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("len0_err", err, 1'b1);
    chk("len0_ready", bus.s_ready, 1'b0);
    chk("len0_hold", cpu_hold, 1'b1);
    pulse_start();
    load(8'hBC, 0, 3, 8);
    chk("start_in_hi_done", done, 1'b1);
    chk("start_in_hi_hold", cpu_hold, 1'b0);
    repeat (3) @(negedge clk);
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL writes_missing: got %0d left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
